// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDop encodings,
// default latencies, HI/LO pair type and the FSM state type.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_mfhi  = 3'd0,
    MD_mflo  = 3'd1,
    MD_mthi  = 3'd2,
    MD_mtlo  = 3'd3,
    MD_mult  = 3'd4,
    MD_multu = 3'd5,
    MD_div   = 3'd6,
    MD_divu  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // Counter width able to hold the larger of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage request/response bundle between the pipeline and the MD sequencer.
interface md_sequencer_if;
  import md_sequencer_pkg::*;

  logic        start;
  md_op_e      MDop;
  logic        flush;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDop, flush, A, B, input  busy, out, HI, LO);
  modport slave  (input  start, MDop, flush, A, B, output busy, out, HI, LO);

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational 32x32 multiply/divide producing the {hi,lo} result,
// including divide-by-zero (keep current HI/LO) and INT_MIN/-1 handling.
module md_arith
  import md_sequencer_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  hilo_t       cur_i,
  output hilo_t       res_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0] q_mag, r_mag, q_u, r_u;
  logic        b_zero, neg_q, neg_r;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    res_o    = cur_i;
    // Sign-extended operands give the signed product in the low 64 bits.
    prod_s   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u   = {32'b0, a_i} * {32'b0, b_i};
    b_zero   = (b_i == 32'd0);
    a_mag    = a_i[31] ? -a_i : a_i;
    b_mag    = b_i[31] ? -b_i : b_i;
    b_safe_s = b_zero ? 32'd1 : b_mag;
    b_safe_u = b_zero ? 32'd1 : b_i;
    // Magnitude division: INT_MIN/-1 falls out as 0x80000000 rem 0.
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    q_u      = a_i / b_safe_u;
    r_u      = a_i % b_safe_u;
    neg_q    = a_i[31] ^ b_i[31];
    neg_r    = a_i[31];

    case (op_i)
      MD_mult:  res_o = hilo_t'(prod_s);
      MD_multu: res_o = hilo_t'(prod_u);
      MD_div: begin
        if (!b_zero) begin
          res_o.hi = neg_r ? -r_mag : r_mag;
          res_o.lo = neg_q ? -q_mag : q_mag;
        end
      end
      MD_divu: begin
        if (!b_zero) begin
          res_o.hi = r_u;
          res_o.lo = q_u;
        end
      end
      default: res_o = cur_i;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner for the E stage: computes the MD result on accept, holds it
// pending for a fixed latency, then commits it to HI/LO.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  localparam int unsigned CNT_W = cnt_width(MULT_LAT, DIV_LAT);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            pend_q, pend_d;
  hilo_t            hilo_q, hilo_d;
  hilo_t            arith_res;
  logic             idle, accept, mt_req, last;

  md_arith u_arith (
    .op_i  (md.MDop),
    .a_i   (md.A),
    .b_i   (md.B),
    .cur_i (hilo_q),
    .res_o (arith_res)
  );

  assign idle   = (state_q == ST_IDLE);
  assign accept = md.start & ~md.flush & idle & md.MDop[2];
  assign mt_req = ~md.flush & ((md.MDop == MD_mthi) | (md.MDop == MD_mtlo));
  assign last   = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hilo_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hilo_q  <= hilo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last)   state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hilo_d = hilo_q;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last) hilo_d = pend_q;
    end else if (accept) begin
      cnt_d  = md.MDop[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      pend_d = arith_res;
    end else if (mt_req) begin
      if (md.MDop == MD_mthi) hilo_d.hi = md.A;
      else                    hilo_d.lo = md.A;
    end
  end

  always_comb begin
    md.busy = (md.start & ~md.flush) | (cnt_q != '0);
    md.out  = (md.MDop == MD_mflo) ? hilo_q.lo : hilo_q.hi;
  end

  assign md.HI = hilo_q.hi;
  assign md.LO = hilo_q.lo;

  // The hazard unit must keep new MD requests out of E while an op is in flight.
  a_no_req_while_run: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_RUN) |-> !((md.start & ~md.flush) | mt_req));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios then random traffic,
// compared cycle by cycle against a cycle-number based reference model.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MULT_LAT = MULT_LAT_DEF;
  localparam int DIV_LAT  = DIV_LAT_DEF;

  logic clk = 1'b0;
  logic reset;

  md_sequencer_if md_bus();

  md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural HI/LO, the pending result and the last busy cycle.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          inflight;
  int          done_cyc;
  int          cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          q, r;
    case (op)
      MD_mult:  return 64'(sa * sb);
      MD_multu: return 64'(ua * ub);
      MD_div: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_divu: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // One cycle: drive at negedge, check combinational/registered outputs, then advance the model.
  task automatic step(input logic st, input md_op_e op, input logic fl,
                      input logic [31:0] a, input logic [31:0] b);
    logic        exp_busy;
    logic [31:0] exp_out;
    logic [63:0] res;
    @(negedge clk);
    md_bus.start = st;
    md_bus.MDop  = op;
    md_bus.flush = fl;
    md_bus.A     = a;
    md_bus.B     = b;
    #1;
    exp_busy = (st & ~fl) | (inflight && cyc <= done_cyc);
    exp_out  = (op == MD_mflo) ? m_lo : m_hi;
    check("busy", 32'(md_bus.busy), 32'(exp_busy));
    check("out",  md_bus.out, exp_out);
    check("HI",   md_bus.HI,  m_hi);
    check("LO",   md_bus.LO,  m_lo);
    @(posedge clk);
    if (inflight && cyc == done_cyc) begin
      m_hi     = p_hi;
      m_lo     = p_lo;
      inflight = 1'b0;
    end else if (!inflight && st && !fl && (op inside {MD_mult, MD_multu, MD_div, MD_divu})) begin
      res      = ref_result(op, a, b, m_hi, m_lo);
      p_hi     = res[63:32];
      p_lo     = res[31:0];
      inflight = 1'b1;
      done_cyc = cyc + (((op == MD_div) || (op == MD_divu)) ? DIV_LAT : MULT_LAT);
    end else if (!inflight && !fl && op == MD_mthi) begin
      m_hi = a;
    end else if (!inflight && !fl && op == MD_mtlo) begin
      m_lo = a;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MD_mfhi, 1'b0, 32'd0, 32'd0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic reset_now(input string tag);
    @(negedge clk);
    md_bus.start = 1'b0;
    md_bus.MDop  = MD_mfhi;
    md_bus.flush = 1'b0;
    reset        = 1'b1;
    #1;
    check({tag, "_busy"}, 32'(md_bus.busy), 32'd0);
    check({tag, "_HI"},   md_bus.HI,  32'd0);
    check({tag, "_LO"},   md_bus.LO,  32'd0);
    check({tag, "_out"},  md_bus.out, 32'd0);
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    inflight = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    md_op_e      op;
    logic        st, fl;
    int          r;

    md_bus.start = 1'b0;
    md_bus.MDop  = MD_mfhi;
    md_bus.flush = 1'b0;
    md_bus.A     = 32'd0;
    md_bus.B     = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
    inflight = 1'b0; done_cyc = 0; cyc = 0;

    reset_now("por");
    idle_steps(1);

    // mthi then mfhi; mtlo under flush must not write LO.
    step(1'b0, MD_mthi, 1'b0, 32'h1234_5678, 32'd0);
    step(1'b0, MD_mfhi, 1'b0, 32'd0, 32'd0);
    check("mthi_out", md_bus.out, 32'h1234_5678);
    step(1'b0, MD_mtlo, 1'b1, 32'hDEAD_BEEF, 32'd0);
    step(1'b0, MD_mflo, 1'b0, 32'd0, 32'd0);
    check("mtlo_flush_LO", md_bus.LO, 32'd0);

    // Flushed mult: no busy, no counter start.
    step(1'b1, MD_mult, 1'b1, 32'd7, 32'd9);
    step(1'b0, MD_mfhi, 1'b0, 32'd0, 32'd0);
    check("flush_mult_busy", 32'(md_bus.busy), 32'd0);

    // mult -3*5: busy T0..T5, HI/LO change only at T6.
    step(1'b1, MD_mult, 1'b0, 32'hFFFF_FFFD, 32'd5);
    idle_steps(MULT_LAT);
    check("mult_HI_held", md_bus.HI, 32'h1234_5678);
    step(1'b0, MD_mflo, 1'b0, 32'd0, 32'd0);
    check("mult_HI", md_bus.HI, 32'hFFFF_FFFF);
    check("mult_LO", md_bus.LO, 32'hFFFF_FFF1);

    step(1'b1, MD_multu, 1'b0, 32'hFFFF_FFFF, 32'd2);
    idle_steps(MULT_LAT + 1);
    check("multu_HI", md_bus.HI, 32'h0000_0001);
    check("multu_LO", md_bus.LO, 32'hFFFF_FFFE);

    step(1'b1, MD_div, 1'b0, 32'hFFFF_FFF9, 32'd2);
    idle_steps(DIV_LAT + 1);
    check("div_HI", md_bus.HI, 32'hFFFF_FFFF);
    check("div_LO", md_bus.LO, 32'hFFFF_FFFD);

    // Divide by zero: full latency, HI/LO unchanged.
    step(1'b1, MD_divu, 1'b0, 32'd9, 32'd0);
    idle_steps(DIV_LAT);
    check("div0_busy_last", 32'(md_bus.busy), 32'd1);
    idle_steps(1);
    check("div0_busy_done", 32'(md_bus.busy), 32'd0);
    check("div0_HI", md_bus.HI, 32'hFFFF_FFFF);
    check("div0_LO", md_bus.LO, 32'hFFFF_FFFD);

    step(1'b1, MD_div, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_steps(DIV_LAT + 1);
    check("ovf_HI", md_bus.HI, 32'h0000_0000);
    check("ovf_LO", md_bus.LO, 32'h8000_0000);

    // Reset at T4 of a div drops the pending result; a later mult still completes.
    step(1'b1, MD_div, 1'b0, 32'd100, 32'd7);
    idle_steps(3);
    reset_now("midrun");
    step(1'b1, MD_mult, 1'b0, 32'd6, 32'd7);
    idle_steps(MULT_LAT + 1);
    check("post_rst_LO", md_bus.LO, 32'd42);
    check("post_rst_HI", md_bus.HI, 32'd0);

    // Random traffic, never issuing MD requests while an operation is in flight.
    for (int i = 0; i < 500; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      if (!inflight) begin
        op = md_op_e'($urandom_range(0, 7));
        st = (op inside {MD_mult, MD_multu, MD_div, MD_divu}) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        r  = $urandom_range(0, 5);
        op = md_op_e'((r < 2) ? r : r + 2);
        st = 1'b0;
      end
      step(st, op, fl, rand_word(), rand_word());
    end
    idle_steps(DIV_LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the E stage of the pipelined MIPS core.
- Owns the HI/LO architectural registers and accepts mult/multu/div/divu plus mthi/mtlo/mfhi/mflo.
- Models the fixed-latency MDU: result is computed at start, held pending, and committed after a programmable delay.
- Drives the busy signal the hazard unit uses to stall MD-type instructions in D.

Parameters:
- MULT_LAT, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
- DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage mult/multu/div/divu present
- MDop  in  3  operation code (package encoding)
- flush  in  1  exception request this cycle; cancels same-cycle start/mthi/mtlo
- A  in  32  forwarded rs operand
- B  in  32  forwarded rt operand
- busy  out  1  MDU occupied; combinational
- out  out  32  read data: LO when MDop==MD_mflo, else HI
- HI  out  32  architectural HI (debug/trace)
- LO  out  32  architectural LO (debug/trace)

Behaviour:
- Reset (async): HI=0, LO=0, cnt=0, pend_hi=0, pend_lo=0, state IDLE; busy=0, out=0.
- MDop encoding: 0 mfhi/no-op, 1 mflo, 2 mthi, 3 mtlo, 4 mult, 5 multu, 6 div, 7divu.
- States: IDLE (cnt==0), RUN (cnt!=0).
- Accept condition: start & ~flush & state==IDLE & MDop in 4..7.
- On accept:
  - latch result into pend_hi/pend_lo.
  - cnt <= MULT_LAT for mult/multu, DIV_LAT for div/divu.
  - go to RUN.
- Results:
  - mult: 64-bit signed product, {pend_hi,pend_lo}.
  - multu: 64-bit unsigned product.
  - div: LO=signed quotient (truncate toward zero), HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor==0: pending values equal the current HI/LO, so the commit leaves them unchanged. cnt and busy still run the full DIV_LAT.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- RUN: cnt decrements each cycle. On the edge where cnt==1: HI<=pend_hi, LO<=pend_lo, cnt<=0, back to IDLE.
- busy = (start & ~flush) | (cnt!=0).
  - Busy is high for LAT+1 cycles: accept cycle T0 through T0+LAT.
  - New HI/LO are visible from cycle T0+LAT+1.
- mthi/mtlo (MDop 2/3) & ~flush & IDLE: HI<=A or LO<=A at the next edge.
- mthi/mtlo while RUN: ignored, simulation assertion. The hazard unit stalls these cases.
- start while RUN: ignored, simulation assertion.
- flush only suppresses same-cycle accept/mthi/mtlo. An in-flight operation always commits; the flushed instruction never reaches E again.
- out is combinational from the HI/LO registers. It does not bypass pending values.
- reset asserted mid-RUN: immediate return to reset values; the pending result is lost.

Decomposition:
- Shared package (Gobals.v): MD_mfhi..MD_divu encodings (3-bit), MULT_LAT and DIV_LAT defaults.
- One natural sub-module: md_arith, a combinational 32x32 signed/unsigned multiply and divide producing {hi,lo}. It includes the div-by-zero and overflow rules.
- md_sequencer keeps the counter, pending registers, HI/LO, and the busy/out logic.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=5 -> busy high T0..T5; HI=0xFFFFFFFF, LO=0xFFFFFFF1 at T6; values unchanged at T5.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 6 busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=9, B=0 -> HI/LO unchanged, busy still 11 cycles.
- mthi A=0x12345678, then MDop=mfhi -> out=0x12345678 next cycle. mtlo with flush=1 -> LO unchanged.
- start mult with flush=1 -> busy=0 that cycle, cnt stays 0, HI/LO unchanged.
- Start div, assert reset at T4 -> HI=LO=0, busy=0 immediately. After reset release a new mult completes normally.
